base_rrrecent_arb: RTL and testbench



---
 rtl/base_rrrecent_arb.sv | 166 ++++++++++++++++
 tb/tb_base_rrrecent_arb.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_rrrecent_arb.sv
// ---------------------------------------------------------------------------
// base_rrrecent_arb
//
// Round-robin arbiter feeding a single overwritable "most recent value"
// holding register. Each cycle at most one valid producer is granted. Its
// data replaces the held value, which is offered downstream with a
// valid/ready handshake and tagged with the source index.
//
// Parameters:
//   width  - data width per producer
//   ways   - number of producers (2..16)
//   swidth - source-index width (ways <= 2**swidth)
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   i_v        in   [ways]        per-producer valid
//   i_r        out  [ways]        per-producer grant (one-hot or zero)
//   i_d        in   [ways*width]  producer data, producer k at [k*width +: width]
//   o_r        in   consumer ready
//   o_v        out  holding register valid
//   o_d        out  [width]       most recently granted data
//   o_s        out  [swidth]      index of the producer that supplied o_d
//
// Optional feature (macro BASE_RRRECENT_ARB_DROPCNT_EN):
//   i_drop_clr in   clears the drop counter next cycle (wins over increment)
//   o_drop     out  [16] saturating count of captures that overwrote an
//                   unconsumed value
// ---------------------------------------------------------------------------
module base_rrrecent_arb #(
    parameter int width  = 1,
    parameter int ways   = 4,
    parameter int swidth = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ways-1:0]         i_v,
    output logic [ways-1:0]         i_r,
    input  logic [ways*width-1:0]   i_d,
    input  logic                    o_r,
    output logic                    o_v,
    output logic [width-1:0]        o_d,
    output logic [swidth-1:0]       o_s
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
    ,
    input  logic                    i_drop_clr,
    output logic [15:0]             o_drop
`endif
);

    logic [swidth-1:0] ptr_q, ptr_d;
    logic              o_v_q, o_v_d;
    logic [width-1:0]  o_d_q, o_d_d;
    logic [swidth-1:0] o_s_q, o_s_d;

    logic              grant_any;
    logic [swidth-1:0] grant_idx;
    logic [width-1:0]  grant_data;

    // Round-robin search starting at ptr_q with wrap: the first requester at
    // or above the pointer wins; failing that, the lowest requester overall
    // (which is necessarily below the pointer) wins.
    always_comb begin
        logic              hi_found;
        logic              lo_found;
        logic [swidth-1:0] hi_idx;
        logic [swidth-1:0] lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int unsigned k = 0; k < ways; k++) begin
            if (i_v[k] && (k >= 32'(ptr_q)) && !hi_found) begin
                hi_found = 1'b1;
                hi_idx   = swidth'(k);
            end
            if (i_v[k] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = swidth'(k);
            end
        end
        grant_any = lo_found;
        grant_idx = hi_found ? hi_idx : lo_idx;
    end

    // Data mux for the granted producer.
    always_comb begin
        grant_data = '0;
        for (int unsigned k = 0; k < ways; k++) begin
            if (swidth'(k) == grant_idx) begin
                grant_data = i_d[k*width +: width];
            end
        end
    end

    // Grant is independent of o_r: the holding register can always be
    // overwritten. Suppressed while reset is asserted.
    always_comb begin
        i_r = '0;
        for (int unsigned k = 0; k < ways; k++) begin
            if (grant_any && !reset && (swidth'(k) == grant_idx)) begin
                i_r[k] = 1'b1;
            end
        end
    end

    // Capture takes precedence over consume: a simultaneous consume and
    // capture leaves o_v set with the new value.
    always_comb begin
        ptr_d = ptr_q;
        o_v_d = o_v_q;
        o_d_d = o_d_q;
        o_s_d = o_s_q;
        if (grant_any) begin
            o_v_d = 1'b1;
            o_d_d = grant_data;
            o_s_d = grant_idx;
            ptr_d = (grant_idx == swidth'(ways - 1)) ? '0 : grant_idx + 1'b1;
        end else if (o_r) begin
            o_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            o_v_q <= 1'b0;
            o_d_q <= '0;
            o_s_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            o_v_q <= o_v_d;
            o_d_q <= o_d_d;
            o_s_q <= o_s_d;
        end
    end

    assign o_v = o_v_q;
    assign o_d = o_d_q;
    assign o_s = o_s_q;

`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
    logic [15:0] drop_q, drop_d;

    // A drop is a capture while an unconsumed value is held.
    always_comb begin
        drop_d = drop_q;
        if (i_drop_clr) begin
            drop_d = '0;
        end else if (grant_any && o_v_q && !o_r && (drop_q != '1)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign o_drop = drop_q;
`endif

endmodule

// File: tb/tb_base_rrrecent_arb.sv
module tb_base_rrrecent_arb;

    localparam int W = 8;
    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   i_v;
    logic [N-1:0]   i_r;
    logic [N*W-1:0] i_d;
    logic           o_r;
    logic           o_v;
    logic [W-1:0]   o_d;
    logic [S-1:0]   o_s;
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
    logic           i_drop_clr;
    logic [15:0]    o_drop;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural reference state
    int           m_ptr;
    logic         m_ov;
    logic [W-1:0] m_od;
    logic [S-1:0] m_os;
    int           m_drop;

    always #5 clk = ~clk;

    base_rrrecent_arb #(.width(W), .ways(N), .swidth(S)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_v        (i_v),
        .i_r        (i_r),
        .i_d        (i_d),
        .o_r        (o_r),
        .o_v        (o_v),
        .o_d        (o_d),
        .o_s        (o_s)
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
        ,
        .i_drop_clr (i_drop_clr),
        .o_drop     (o_drop)
`endif
    );

    // Round-robin rule: scan ptr, ptr+1, ... modulo N; first valid wins.
    function automatic int model_grant(input logic [N-1:0] v);
        for (int off = 0; off < N; off++) begin
            if (v[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    // Applies one cycle of stimulus (starting just after a negedge), returns
    // the observed and expected grant vector, advances the model at the
    // rising edge and returns just after the following negedge.
    task automatic run_cycle(input logic rst, input logic [N-1:0] v,
                             input logic [N*W-1:0] d, input logic rdy,
                             input logic clr,
                             output logic [N-1:0] obs_ir,
                             output logic [N-1:0] exp_ir);
        int g;
        reset = rst;
        i_v   = v;
        i_d   = d;
        o_r   = rdy;
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
        i_drop_clr = clr;
`endif
        #1;
        obs_ir = i_r;
        g      = model_grant(v);
        exp_ir = '0;
        if (!rst && g >= 0) exp_ir[g] = 1'b1;
        @(posedge clk);
        if (rst) begin
            m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = '0; m_drop = 0;
        end else begin
            if (clr) m_drop = 0;
            else if (g >= 0 && m_ov && !rdy && m_drop < 65535) m_drop++;
            if (g >= 0) begin
                m_od  = d[g*W +: W];
                m_os  = S'(g);
                m_ov  = 1'b1;
                m_ptr = (g + 1) % N;
            end else if (rdy) begin
                m_ov = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    function automatic logic [N*W-1:0] rand_data();
        logic [N*W-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic test_reset();
        logic [N-1:0] oir, eir;
        for (int c = 0; c < 2; c++) begin
            run_cycle(1'b1, 4'b1111, rand_data(), 1'b1, 1'b0, oir, eir);
            checks++;
            if (oir !== 4'b0000) begin
                errors++; $display("FAIL reset_ir got %b exp 0000", oir);
            end
            checks++;
            if ({o_v, o_s, o_d} !== '0) begin
                errors++; $display("FAIL reset_out got v=%b s=%0d d=%h exp all zero", o_v, o_s, o_d);
            end
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
            checks++;
            if (o_drop !== 16'd0) begin
                errors++; $display("FAIL reset_drop got %0d exp 0", o_drop);
            end
`endif
        end
        run_cycle(1'b0, 4'b1111, rand_data(), 1'b1, 1'b0, oir, eir);
        checks++;
        if (oir !== 4'b0001) begin
            errors++; $display("FAIL post_reset_ir got %b exp 0001", oir);
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0]   oir, eir;
        logic [N*W-1:0] d;
        for (int c = 0; c < 8; c++) begin
            d = rand_data();
            run_cycle(1'b0, 4'b1111, d, 1'b1, 1'b0, oir, eir);
            checks++;
            if (oir !== eir) begin
                errors++; $display("FAIL rotation_ir[%0d] got %b exp %b", c, oir, eir);
            end
            checks++;
            if ({o_v, o_s, o_d} !== {1'b1, m_os, m_od}) begin
                errors++;
                $display("FAIL rotation_out[%0d] got v=%b s=%0d d=%h exp v=1 s=%0d d=%h",
                         c, o_v, o_s, o_d, m_os, m_od);
            end
        end
    endtask

    task automatic test_skip_wrap();
        logic [N-1:0] oir, eir;
        run_cycle(1'b0, 4'b0010, rand_data(), 1'b1, 1'b0, oir, eir);
        run_cycle(1'b0, 4'b0011, rand_data(), 1'b1, 1'b0, oir, eir);
        checks++;
        if (oir !== 4'b0001) begin
            errors++; $display("FAIL skip_wrap_first got %b exp 0001", oir);
        end
        run_cycle(1'b0, 4'b0011, rand_data(), 1'b1, 1'b0, oir, eir);
        checks++;
        if (oir !== 4'b0010) begin
            errors++; $display("FAIL skip_wrap_second got %b exp 0010", oir);
        end
        checks++;
        if (o_s !== 2'd1) begin
            errors++; $display("FAIL skip_wrap_src got %0d exp 1", o_s);
        end
    endtask

    task automatic test_overwrite();
        logic [N-1:0]   oir, eir;
        logic [N*W-1:0] d;
        // Drain and clear the counter first.
        run_cycle(1'b0, 4'b0000, rand_data(), 1'b1, 1'b1, oir, eir);
        d = rand_data(); d[2*W +: W] = 8'hA5;
        run_cycle(1'b0, 4'b0100, d, 1'b0, 1'b0, oir, eir);
        d = rand_data(); d[3*W +: W] = 8'h3C;
        run_cycle(1'b0, 4'b1000, d, 1'b0, 1'b0, oir, eir);
        checks++;
        if ({o_v, o_s, o_d} !== {1'b1, 2'd3, 8'h3C}) begin
            errors++; $display("FAIL overwrite got v=%b s=%0d d=%h exp v=1 s=3 d=3c", o_v, o_s, o_d);
        end
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
        checks++;
        if (o_drop !== 16'd1) begin
            errors++; $display("FAIL overwrite_drop got %0d exp 1", o_drop);
        end
`endif
    endtask

    task automatic test_consume_refill();
        logic [N-1:0]   oir, eir;
        logic [N*W-1:0] d;
        d = rand_data(); d[0 +: W] = 8'h11;
        run_cycle(1'b0, 4'b0001, d, 1'b0, 1'b0, oir, eir);
        checks++;
        if ({o_v, o_d} !== {1'b1, 8'h11}) begin
            errors++; $display("FAIL refill_setup got v=%b d=%h exp v=1 d=11", o_v, o_d);
        end
        d = rand_data(); d[0 +: W] = 8'h22;
        run_cycle(1'b0, 4'b0001, d, 1'b1, 1'b0, oir, eir);
        checks++;
        if ({o_v, o_d} !== {1'b1, 8'h22}) begin
            errors++; $display("FAIL refill_same_cycle got v=%b d=%h exp v=1 d=22", o_v, o_d);
        end
        run_cycle(1'b0, 4'b0000, rand_data(), 1'b1, 1'b0, oir, eir);
        checks++;
        if ({o_v, o_d} !== {1'b0, 8'h22}) begin
            errors++; $display("FAIL consume_drain got v=%b d=%h exp v=0 d=22", o_v, o_d);
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] oir, eir;
        run_cycle(1'b0, 4'b0100, rand_data(), 1'b0, 1'b0, oir, eir);
        run_cycle(1'b1, 4'b1000, rand_data(), 1'b0, 1'b0, oir, eir);
        checks++;
        if (oir !== 4'b0000) begin
            errors++; $display("FAIL reset_mid_ir got %b exp 0000", oir);
        end
        checks++;
        if (o_v !== 1'b0) begin
            errors++; $display("FAIL reset_mid_ov got %b exp 0", o_v);
        end
        run_cycle(1'b0, 4'b1001, rand_data(), 1'b0, 1'b0, oir, eir);
        checks++;
        if (oir !== 4'b0001) begin
            errors++; $display("FAIL reset_mid_ptr got %b exp 0001", oir);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] oir, eir;
        logic         rst, clr;
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 39) == 0);
            clr = ($urandom_range(0, 19) == 0);
            run_cycle(rst, N'($urandom), rand_data(), 1'($urandom), clr, oir, eir);
            checks++;
            if (oir !== eir) begin
                errors++; $display("FAIL random_ir[%0d] got %b exp %b", c, oir, eir);
            end
            checks++;
            if ({o_v, o_s, o_d} !== {m_ov, m_os, m_od}) begin
                errors++;
                $display("FAIL random_out[%0d] got v=%b s=%0d d=%h exp v=%b s=%0d d=%h",
                         c, o_v, o_s, o_d, m_ov, m_os, m_od);
            end
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
            checks++;
            if (o_drop !== 16'(m_drop)) begin
                errors++; $display("FAIL random_drop[%0d] got %0d exp %0d", c, o_drop, m_drop);
            end
`endif
        end
    endtask

    initial begin
        reset = 1'b1;
        i_v   = '0;
        i_d   = '0;
        o_r   = 1'b0;
`ifdef BASE_RRRECENT_ARB_DROPCNT_EN
        i_drop_clr = 1'b0;
`endif
        m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = '0; m_drop = 0;
        @(negedge clk);
        test_reset();
        test_rotation();
        test_skip_wrap();
        test_overwrite();
        test_consume_refill();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
